// File: rtl/execute_md_stage.sv
// Execute stage: bypass operand muxes, single-cycle ALU, branch-target adder and an
// iterative unsigned multiply/divide unit that stalls the pipeline while it runs.
module execute_md_stage #(
  parameter int  DATA_W   = 32,
  parameter int  ADDR_W   = 5,
  parameter int  PC_W     = 32,
  parameter int  ALU_OP_W = 3,
  parameter int  NUM_BYP  = 2,
  parameter int  CTRL_W   = 5,
  localparam int SEL_W    = $clog2(NUM_BYP + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      has_imm_i,
  input  logic [ALU_OP_W-1:0]       alu_op_i,
  input  logic                      alu_alt_i,
  input  logic                      md_en_i,
  input  logic [1:0]                md_op_i,
  input  logic [CTRL_W-1:0]         ctrl_i,
  input  logic [DATA_W-1:0]         imm32_i,
  input  logic [DATA_W-1:0]         rf_data0_i,
  input  logic [DATA_W-1:0]         rf_data1_i,
  input  logic [ADDR_W-1:0]         rf_waddr_i,
  input  logic [PC_W-1:0]           pc_plus1_i,
  input  logic [NUM_BYP*DATA_W-1:0] byp_data_i,
  input  logic [SEL_W-1:0]          src0_sel_i,
  input  logic [SEL_W-1:0]          src1_sel_i,
  input  logic                      latch_en,
  input  logic                      latch_clear,
  output logic [CTRL_W-1:0]         ctrl_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  output logic [DATA_W-1:0]         alu_result_o,
  output logic [ADDR_W-1:0]         rf_waddr_o,
  output logic [PC_W-1:0]           pc_branch_o,
  output logic                      md_busy_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int SH_W  = CNT_W;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_SR   = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(7);

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  md_state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_hi, r_lo, r_op_b;
  logic [1:0]          r_md_op;
  logic                w_md_start, w_md_step;

  logic [DATA_W-1:0]   w_src0, w_src1, w_op_b, w_alu_result, w_md_result;
  logic [SH_W-1:0]     w_shamt;
  logic [DATA_W:0]     w_mul_sum, w_div_shift;
  logic [DATA_W-1:0]   w_div_diff;
  logic                w_div_ok;

  logic [CTRL_W-1:0]   r_ctrl;
  logic [DATA_W-1:0]   r_mem_wdata, r_alu_result;
  logic [ADDR_W-1:0]   r_rf_waddr;
  logic [PC_W-1:0]     r_pc_branch;

  // Selects beyond the last bypass source read as zero.
  function automatic logic [DATA_W-1:0] f_operand(input logic [SEL_W-1:0]          sel,
                                                  input logic [DATA_W-1:0]         rf,
                                                  input logic [NUM_BYP*DATA_W-1:0] byp);
    f_operand = '0;
    if (sel == '0) f_operand = rf;
    for (int k = 1; k <= NUM_BYP; k++) begin
      if (sel == SEL_W'(k)) f_operand = byp[(k-1)*DATA_W +: DATA_W];
    end
  endfunction

  assign w_src0  = f_operand(src0_sel_i, rf_data0_i, byp_data_i);
  assign w_src1  = f_operand(src1_sel_i, rf_data1_i, byp_data_i);
  assign w_op_b  = has_imm_i ? imm32_i : w_src1;
  assign w_shamt = w_op_b[SH_W-1:0];

  // NOTE: every signal assigned in always_comb gets a default first so no path infers a latch.
  always_comb begin
    w_alu_result = '0;
    case (alu_op_i)
      ALU_ADD:  w_alu_result = alu_alt_i ? (w_src0 - w_op_b) : (w_src0 + w_op_b);
      ALU_SLL:  w_alu_result = w_src0 << w_shamt;
      ALU_SLT:  w_alu_result = DATA_W'($signed(w_src0) < $signed(w_op_b));
      ALU_SLTU: w_alu_result = DATA_W'(w_src0 < w_op_b);
      ALU_XOR:  w_alu_result = w_src0 ^ w_op_b;
      ALU_SR:   w_alu_result = alu_alt_i ? $unsigned($signed(w_src0) >>> w_shamt)
                                         : (w_src0 >> w_shamt);
      ALU_OR:   w_alu_result = w_src0 | w_op_b;
      ALU_AND:  w_alu_result = w_src0 & w_op_b;
      default:  w_alu_result = '0;
    endcase
  end

  // {r_hi, r_lo} is the product accumulator for multiply and {remainder, quotient} for divide.
  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op_b} : '0);
  assign w_div_shift = {r_hi, r_lo[DATA_W-1]};
  assign w_div_ok    = (w_div_shift >= {1'b0, r_op_b});
  assign w_div_diff  = w_div_shift[DATA_W-1:0] - r_op_b;
  assign w_md_result = r_md_op[0] ? r_hi : r_lo;

  always_comb begin
    w_state_nxt = r_state;
    md_busy_o   = 1'b0;
    w_md_start  = 1'b0;
    w_md_step   = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (md_en_i && !latch_clear) begin
          w_state_nxt = MD_BUSY;
          md_busy_o   = 1'b1;
          w_md_start  = 1'b1;
        end
      end
      MD_BUSY: begin
        md_busy_o = 1'b1;
        if (latch_clear) begin
          w_state_nxt = MD_IDLE;
        end else begin
          w_md_step = 1'b1;
          if (r_cnt == '0) w_state_nxt = MD_DONE;
        end
      end
      MD_DONE: begin
        if (latch_clear || latch_en) w_state_nxt = MD_IDLE;
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= MD_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: the MD datapath is a handful of flops, so it is reset explicitly to give a known
  // state after a mid-operation reset rather than relying on the FSM to mask stale values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_op_b  <= '0;
      r_md_op <= '0;
      r_cnt   <= '0;
    end else if (w_md_start) begin
      r_hi    <= '0;
      r_lo    <= w_src0;
      r_op_b  <= w_src1;
      r_md_op <= md_op_i;
      r_cnt   <= CNT_W'(DATA_W - 1);
    end else if (w_md_step) begin
      if (!r_md_op[1]) begin
        {r_hi, r_lo} <= {w_mul_sum, r_lo[DATA_W-1:1]};
      end else begin
        r_hi <= w_div_ok ? w_div_diff : w_div_shift[DATA_W-1:0];
        r_lo <= {r_lo[DATA_W-2:0], w_div_ok};
      end
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Flush and stall bubbles both load zeros into the stage register.
  always_ff @(posedge clk) begin
    if (reset || latch_clear || (latch_en && md_busy_o)) begin
      r_ctrl       <= '0;
      r_mem_wdata  <= '0;
      r_alu_result <= '0;
      r_rf_waddr   <= '0;
      r_pc_branch  <= '0;
    end else if (latch_en) begin
      r_ctrl       <= ctrl_i;
      r_mem_wdata  <= w_src1;
      r_alu_result <= (r_state == MD_DONE) ? w_md_result : w_alu_result;
      r_rf_waddr   <= rf_waddr_i;
      r_pc_branch  <= pc_plus1_i + PC_W'(imm32_i);
    end
  end

  assign ctrl_o       = r_ctrl;
  assign mem_wdata_o  = r_mem_wdata;
  assign alu_result_o = r_alu_result;
  assign rf_waddr_o   = r_rf_waddr;
  assign pc_branch_o  = r_pc_branch;

endmodule

// File: tb/tb_execute_md_stage.sv
// Self-checking bench for execute_md_stage: random ALU traffic and multiply/divide
// operations compared against a plain-arithmetic reference model.
module tb_execute_md_stage;

  logic        clk = 1'b0;
  logic        reset, has_imm_i, alu_alt_i, md_en_i, latch_en, latch_clear;
  logic [2:0]  alu_op_i;
  logic [1:0]  md_op_i;
  logic [4:0]  ctrl_i, rf_waddr_i;
  logic [31:0] imm32_i, rf_data0_i, rf_data1_i, pc_plus1_i;
  logic [63:0] byp_data_i;
  logic [1:0]  src0_sel_i, src1_sel_i;
  logic [4:0]  ctrl_o, rf_waddr_o;
  logic [31:0] mem_wdata_o, alu_result_o, pc_branch_o;
  logic        md_busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  execute_md_stage dut (
    .clk(clk), .reset(reset), .has_imm_i(has_imm_i), .alu_op_i(alu_op_i),
    .alu_alt_i(alu_alt_i), .md_en_i(md_en_i), .md_op_i(md_op_i), .ctrl_i(ctrl_i),
    .imm32_i(imm32_i), .rf_data0_i(rf_data0_i), .rf_data1_i(rf_data1_i),
    .rf_waddr_i(rf_waddr_i), .pc_plus1_i(pc_plus1_i), .byp_data_i(byp_data_i),
    .src0_sel_i(src0_sel_i), .src1_sel_i(src1_sel_i), .latch_en(latch_en),
    .latch_clear(latch_clear), .ctrl_o(ctrl_o), .mem_wdata_o(mem_wdata_o),
    .alu_result_o(alu_result_o), .rf_waddr_o(rf_waddr_o), .pc_branch_o(pc_branch_o),
    .md_busy_o(md_busy_o)
  );

  // Reference model
  function automatic logic [31:0] m_src(input logic [1:0] sel, input logic [31:0] rf,
                                        input logic [63:0] byp);
    case (sel)
      2'd0:    return rf;
      2'd1:    return byp[31:0];
      2'd2:    return byp[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_alu(input logic [2:0] op, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'(int'(a) >>> sh) : a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] m_md(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic drive_idle();
    has_imm_i = 0; alu_op_i = 0; alu_alt_i = 0; md_en_i = 0; md_op_i = 0;
    ctrl_i = 0; imm32_i = 0; rf_data0_i = 0; rf_data1_i = 0; rf_waddr_i = 0;
    pc_plus1_i = 0; byp_data_i = 0; src0_sel_i = 0; src1_sel_i = 0;
    latch_en = 0; latch_clear = 0;
  endtask

  // Issues one MD op, optionally holds DONE for done_wait cycles, then retires it.
  task automatic do_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit rand_src, input int done_wait, input string tag);
    int busy;
    logic [31:0] exp_res, exp_pc;
    logic [4:0]  exp_ctrl, exp_wa;
    exp_ctrl = 5'($urandom); exp_wa = 5'($urandom);
    md_en_i = 1; md_op_i = op; ctrl_i = exp_ctrl; rf_waddr_i = exp_wa;
    alu_op_i = 3'($urandom); alu_alt_i = 1'($urandom);
    has_imm_i = 1; imm32_i = $urandom; pc_plus1_i = $urandom;
    latch_en = 1; latch_clear = 0;
    byp_data_i = {$urandom, $urandom};
    if (rand_src) begin
      src0_sel_i = 2'($urandom); src1_sel_i = 2'($urandom);
      rf_data0_i = $urandom; rf_data1_i = $urandom;
      a = m_src(src0_sel_i, rf_data0_i, byp_data_i);
      b = m_src(src1_sel_i, rf_data1_i, byp_data_i);
    end else begin
      src0_sel_i = 0; src1_sel_i = 0; rf_data0_i = a; rf_data1_i = b;
    end
    exp_res = m_md(op, a, b);
    exp_pc  = pc_plus1_i + imm32_i;
    busy = 0;
    #1;
    while (md_busy_o === 1'b1 && busy < 100) begin
      busy++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (busy != 33) begin
      n_fail++; $display("FAIL %s busy_cycles: got %0d expected 33", tag, busy);
    end
    n_tests++;
    if (ctrl_o !== 5'd0 || alu_result_o !== 32'd0) begin
      n_fail++; $display("FAIL %s bubble: got ctrl=%h res=%h expected 0", tag, ctrl_o, alu_result_o);
    end
    for (int i = 0; i < done_wait; i++) begin
      latch_en = 0;
      @(posedge clk); #1;
      n_tests++;
      if (md_busy_o !== 1'b0 || alu_result_o !== 32'd0 || ctrl_o !== 5'd0) begin
        n_fail++;
        $display("FAIL %s done_hold[%0d]: got busy=%b res=%h ctrl=%h expected 0/0/0",
                 tag, i, md_busy_o, alu_result_o, ctrl_o);
      end
    end
    latch_en = 1;
    @(posedge clk); #1;
    n_tests++;
    if (alu_result_o !== exp_res) begin
      n_fail++; $display("FAIL %s result: got %h expected %h (a=%h b=%h op=%0d)",
                         tag, alu_result_o, exp_res, a, b, op);
    end
    n_tests++;
    if ({ctrl_o, rf_waddr_o, mem_wdata_o, pc_branch_o} !== {exp_ctrl, exp_wa, b, exp_pc}) begin
      n_fail++;
      $display("FAIL %s fields: got ctrl=%h wa=%h wd=%h pc=%h expected %h %h %h %h",
               tag, ctrl_o, rf_waddr_o, mem_wdata_o, pc_branch_o, exp_ctrl, exp_wa, b, exp_pc);
    end
    // md_en still high: a busy request here shows the FSM is back in IDLE.
    n_tests++;
    if (md_busy_o !== 1'b1) begin
      n_fail++; $display("FAIL %s back_to_idle: got busy=%b expected 1", tag, md_busy_o);
    end
    md_en_i = 0;
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1; latch_en = 1; rf_data0_i = $urandom; rf_data1_i = $urandom;
    imm32_i = $urandom; pc_plus1_i = $urandom; ctrl_i = 5'h1F; rf_waddr_i = 5'h11;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({ctrl_o, rf_waddr_o, mem_wdata_o, alu_result_o, pc_branch_o, md_busy_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got ctrl=%h wa=%h wd=%h res=%h pc=%h busy=%b expected all 0",
               ctrl_o, rf_waddr_o, mem_wdata_o, alu_result_o, pc_branch_o, md_busy_o);
    end
    reset = 0;
    drive_idle();
  endtask

  task automatic test_bypass_add();
    drive_idle();
    src0_sel_i = 2; byp_data_i = {32'h10, 32'hDEAD_BEEF}; rf_data0_i = 32'h7777;
    rf_data1_i = 32'h5; src1_sel_i = 0; alu_op_i = 0; latch_en = 1;
    #1;
    n_tests++;
    if (md_busy_o !== 1'b0) begin
      n_fail++; $display("FAIL bypass_add busy: got %b expected 0", md_busy_o);
    end
    @(posedge clk); #1;
    n_tests++;
    if (alu_result_o !== 32'h15) begin
      n_fail++; $display("FAIL bypass_add result: got %h expected 00000015", alu_result_o);
    end
  endtask

  task automatic test_alu_random();
    logic [31:0] a, b, e_res, e_wd, e_pc;
    logic [4:0]  e_ctrl, e_wa;
    e_res = 0; e_wd = 0; e_pc = 0; e_ctrl = 0; e_wa = 0;
    for (int i = 0; i < 60; i++) begin
      md_en_i = 0;
      has_imm_i = 1'($urandom); alu_op_i = 3'($urandom); alu_alt_i = 1'($urandom);
      ctrl_i = 5'($urandom); imm32_i = $urandom; rf_data0_i = $urandom;
      rf_data1_i = $urandom; rf_waddr_i = 5'($urandom); pc_plus1_i = $urandom;
      byp_data_i = {$urandom, $urandom};
      src0_sel_i = 2'($urandom); src1_sel_i = 2'($urandom);
      if (i % 9 == 4) rf_data1_i = 32'h0000_001F;
      latch_clear = (i == 0) || ($urandom_range(0, 7) == 0);
      latch_en = ($urandom_range(0, 3) != 0);
      a = m_src(src0_sel_i, rf_data0_i, byp_data_i);
      b = m_src(src1_sel_i, rf_data1_i, byp_data_i);
      if (latch_clear) begin
        e_res = 0; e_wd = 0; e_pc = 0; e_ctrl = 0; e_wa = 0;
      end else if (latch_en) begin
        e_res = m_alu(alu_op_i, alu_alt_i, a, has_imm_i ? imm32_i : b);
        e_wd = b; e_pc = pc_plus1_i + imm32_i; e_ctrl = ctrl_i; e_wa = rf_waddr_i;
      end
      @(posedge clk); #1;
      n_tests++;
      if ({alu_result_o, mem_wdata_o, pc_branch_o, ctrl_o, rf_waddr_o, md_busy_o} !==
          {e_res, e_wd, e_pc, e_ctrl, e_wa, 1'b0}) begin
        n_fail++;
        $display("FAIL alu_rand[%0d] op=%0d alt=%b: got res=%h wd=%h pc=%h ctrl=%h wa=%h busy=%b expected %h %h %h %h %h 0",
                 i, alu_op_i, alu_alt_i, alu_result_o, mem_wdata_o, pc_branch_o, ctrl_o,
                 rf_waddr_o, md_busy_o, e_res, e_wd, e_pc, e_ctrl, e_wa);
      end
    end
    latch_clear = 0;
    drive_idle();
  endtask

  task automatic test_mul();
    do_md(2'd0, 32'd7, 32'd6, 0, 0, "mul_7x6");
    do_md(2'd1, 32'hFFFF_FFFF, 32'd2, 0, 0, "mulhu_max");
    do_md(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "mul_max");
  endtask

  task automatic test_div();
    do_md(2'd2, 32'd100, 32'd7, 0, 0, "divu_100_7");
    do_md(2'd3, 32'd100, 32'd7, 0, 0, "remu_100_7");
    do_md(2'd2, 32'h1234, 32'd0, 0, 0, "divu_by0");
    do_md(2'd3, 32'h1234, 32'd0, 0, 0, "remu_by0");
    do_md(2'd2, 32'hFFFF_FFFF, 32'd1, 0, 0, "divu_max_1");
  endtask

  task automatic test_random_md();
    for (int i = 0; i < 8; i++) begin
      do_md(2'($urandom), 32'd0, 32'd0, 1, 0, $sformatf("md_rand%0d", i));
    end
  endtask

  task automatic test_done_hold();
    do_md(2'd2, 32'd1000, 32'd33, 0, 3, "done_hold");
  endtask

  task automatic test_clear_busy();
    logic [31:0] e_res;
    drive_idle();
    md_en_i = 1; md_op_i = 2'd0; rf_data0_i = 32'd123; rf_data1_i = 32'd456;
    latch_en = 1; ctrl_i = 5'h1F;
    repeat (10) @(posedge clk);
    #1;
    latch_clear = 1; md_en_i = 0;
    @(posedge clk); #1;
    latch_clear = 0;
    n_tests++;
    if (md_busy_o !== 1'b0 || ctrl_o !== 5'd0 || alu_result_o !== 32'd0) begin
      n_fail++; $display("FAIL clear_busy abort: got busy=%b ctrl=%h res=%h expected 0/0/0",
                         md_busy_o, ctrl_o, alu_result_o);
    end
    rf_data0_i = $urandom; rf_data1_i = $urandom; alu_op_i = 0; alu_alt_i = 0;
    ctrl_i = 5'h0A;
    e_res = rf_data0_i + rf_data1_i;
    @(posedge clk); #1;
    latch_en = 0;
    n_tests++;
    if (alu_result_o !== e_res || ctrl_o !== 5'h0A) begin
      n_fail++; $display("FAIL clear_busy add: got res=%h ctrl=%h expected %h 0a",
                         alu_result_o, ctrl_o, e_res);
    end
    repeat (30) @(posedge clk);
    #1;
    n_tests++;
    if (md_busy_o !== 1'b0 || alu_result_o !== e_res) begin
      n_fail++; $display("FAIL clear_busy no_resume: got busy=%b res=%h expected 0 %h",
                         md_busy_o, alu_result_o, e_res);
    end
    drive_idle();
  endtask

  task automatic test_clear_done();
    int busy;
    drive_idle();
    md_en_i = 1; md_op_i = 2'd0; rf_data0_i = 32'd99; rf_data1_i = 32'd3; latch_en = 1;
    busy = 0;
    #1;
    while (md_busy_o === 1'b1 && busy < 100) begin
      busy++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (busy != 33) begin
      n_fail++; $display("FAIL clear_done busy_cycles: got %0d expected 33", busy);
    end
    latch_clear = 1;
    @(posedge clk); #1;
    latch_clear = 0;
    n_tests++;
    if (alu_result_o !== 32'd0 || ctrl_o !== 5'd0) begin
      n_fail++; $display("FAIL clear_done discard: got res=%h ctrl=%h expected 0", alu_result_o, ctrl_o);
    end
    #1;
    n_tests++;
    if (md_busy_o !== 1'b1) begin
      n_fail++; $display("FAIL clear_done idle: got busy=%b expected 1", md_busy_o);
    end
    drive_idle();
    #1;
  endtask

  task automatic test_reset_mid_div();
    drive_idle();
    rf_data0_i = 32'h100; rf_data1_i = 32'h23; imm32_i = 32'h40; pc_plus1_i = 32'h1000;
    ctrl_i = 5'h1F; rf_waddr_i = 5'd7; latch_en = 1;
    @(posedge clk); #1;
    md_en_i = 1; md_op_i = 2'd2; latch_en = 0;
    repeat (6) @(posedge clk);
    #1;
    n_tests++;
    if (md_busy_o !== 1'b1 || alu_result_o !== 32'h123 || pc_branch_o !== 32'h1040) begin
      n_fail++; $display("FAIL reset_mid_div pre: got busy=%b res=%h pc=%h expected 1 123 1040",
                         md_busy_o, alu_result_o, pc_branch_o);
    end
    reset = 1; md_en_i = 0;
    @(posedge clk); #1;
    n_tests++;
    if ({ctrl_o, rf_waddr_o, mem_wdata_o, alu_result_o, pc_branch_o, md_busy_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_div: got ctrl=%h wa=%h wd=%h res=%h pc=%h busy=%b expected all 0",
               ctrl_o, rf_waddr_o, mem_wdata_o, alu_result_o, pc_branch_o, md_busy_o);
    end
    reset = 0;
    @(posedge clk); #1;
    do_md(2'd0, 32'd12345, 32'd6789, 0, 0, "mul_after_reset");
  endtask

  initial begin
    reset = 1;
    drive_idle();
    test_reset();
    test_bypass_add();
    test_alu_random();
    test_mul();
    test_div();
    test_random_md();
    test_done_hold();
    test_clear_busy();
    test_clear_done();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
